// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: control-byte bit positions, MEM-stage FSM states
// and the hardwired-zero register index.
package riscv_pipe_pkg;

    localparam int unsigned CTL_ALU_SRC    = 7;
    localparam int unsigned CTL_MEM_TO_REG = 6;
    localparam int unsigned CTL_REG_WRITE  = 5;
    localparam int unsigned CTL_MEM_READ   = 4;
    localparam int unsigned CTL_MEM_WRITE  = 3;
    localparam int unsigned CTL_BRANCH     = 2;
    localparam int unsigned CTL_ALU_OP     = 0;   // low bit of the 2-bit alu_op field

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_t;

endpackage

// File: rtl/dmem_if_fsm.sv
// Data-memory req/ready sequencer with access timeout. Reports completion,
// a one-cycle abort after a timeout, and the pipeline stall request.
module dmem_if_fsm
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic dmem_ready,
    output logic busy,
    output logic done,
    output logic abort,
    output logic stall
);

    localparam int unsigned   TW     = $clog2(MEM_TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(MEM_TIMEOUT - 1);

    mem_state_t    state;
    logic [TW-1:0] timer;
    logic          abort_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            timer   <= '0;
            abort_q <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    timer <= '0;
                    if (start) state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // A completing access may hand straight over to the next one
                    if (dmem_ready) begin
                        timer <= '0;
                        state <= start ? ST_ACCESS : ST_IDLE;
                    end else if (timer == T_LAST) begin
                        timer   <= '0;
                        state   <= ST_IDLE;
                        abort_q <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy  = (state == ST_ACCESS);
    assign done  = busy && dmem_ready;
    assign stall = busy && !dmem_ready;
    assign abort = abort_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: EX/MEM register, word load/store over req/ready,
// forwarding back to EX, branch redirect to IF and registered writeback.
module mem_access_stage
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  input_control,
    input  logic [4:0]  input_reg_addr,
    input  logic [31:0] input_pc,
    input  logic [31:0] input_ALU_result,
    input  logic [31:0] input_write_data,
    input  logic        input_zero_flag,
    output logic [4:0]  output_mempro_addr,
    output logic [31:0] output_mempro_data,
    output logic        output_mempro_load,
    output logic        output_stall,
    output logic        output_pc_src,
    output logic [31:0] output_branch_pc,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_reg_addr,
    output logic [31:0] wb_data,
    output logic        output_mem_err
);

    logic [7:0]  ctl_q;
    logic [4:0]  rd_q;
    logic [31:0] alu_q;
    logic [31:0] wdata_q;
    logic        misalign_q;
    logic        pc_src_q;
    logic [31:0] branch_pc_q;

    logic busy, done, abort, stall;
    logic in_mem, in_aligned, start;
    logic is_load, eff_rw;
    logic [31:0] load_data;
    logic unused_ctl;

    assign in_mem     = input_control[CTL_MEM_READ] | input_control[CTL_MEM_WRITE];
    assign in_aligned = (input_ALU_result[1:0] == 2'b00);
    // Access starts on the same edge that latches the instruction, so ready in
    // the first MEM cycle completes without any stall.
    assign start      = !stall && in_mem && in_aligned;

    dmem_if_fsm #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dmem_ready(dmem_ready),
        .busy      (busy),
        .done      (done),
        .abort     (abort),
        .stall     (stall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q       <= '0;
            rd_q        <= '0;
            alu_q       <= '0;
            wdata_q     <= '0;
            misalign_q  <= 1'b0;
            pc_src_q    <= 1'b0;
            branch_pc_q <= '0;
        end else if (!stall) begin
            ctl_q       <= input_control;
            rd_q        <= input_reg_addr;
            alu_q       <= input_ALU_result;
            wdata_q     <= input_write_data;
            misalign_q  <= in_mem && !in_aligned;
            pc_src_q    <= input_control[CTL_BRANCH] && input_zero_flag;
            branch_pc_q <= input_pc;
        end else begin
            pc_src_q    <= 1'b0;
        end
    end

    assign is_load   = ctl_q[CTL_MEM_READ];
    assign eff_rw    = ctl_q[CTL_REG_WRITE] && (rd_q != REG_X0) && !misalign_q && !abort;
    assign load_data = done ? dmem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_reg_addr  <= '0;
            wb_data      <= '0;
        end else if (stall) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
        end else begin
            wb_valid     <= (ctl_q != '0);
            wb_reg_write <= eff_rw;
            wb_reg_addr  <= rd_q;
            wb_data      <= is_load ? load_data : alu_q;
        end
    end

    assign output_mempro_addr = eff_rw ? rd_q : REG_X0;
    assign output_mempro_data = is_load ? load_data : alu_q;
    assign output_mempro_load = eff_rw && is_load && !done;
    assign output_stall       = stall;
    assign output_pc_src      = pc_src_q;
    assign output_branch_pc   = branch_pc_q;
    assign output_mem_err     = misalign_q | abort;

    assign dmem_req   = busy;
    assign dmem_we    = busy && ctl_q[CTL_MEM_WRITE];
    assign dmem_addr  = busy ? {alu_q[31:2], 2'b00} : '0;
    assign dmem_wdata = busy ? wdata_q : '0;

    assign unused_ctl = ^{ctl_q[CTL_ALU_SRC], ctl_q[CTL_MEM_TO_REG], ctl_q[CTL_ALU_OP +: 2]};

endmodule
